// File: rtl/occupancy_grid_arbiter.sv
// -----------------------------------------------------------------------------
// occupancy_grid_arbiter
//
// Owns the single-port occupancy grid RAM. Three clients share it:
//   - a full-grid zero sweep started by clear_start (from the control unit),
//   - log-odds read-modify-write updates from the Bresenham cell walker,
//   - host reads.
// Updates add LOG_ODDS_HIT (hit) or subtract LOG_ODDS_MISS (miss) with the
// result clamped to the signed CELL_WIDTH range.
//
// Ports
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   clear_start           one-cycle pulse requesting a zero sweep
//   busy                  (state != IDLE) | clear_pending, feeds occupancy_busy
//   upd_valid/upd_ready   update request channel, upd_addr / upd_hit payload
//   rd_valid/rd_ready     read request channel, rd_addr payload
//   rd_data_valid/rd_data one-cycle pulse with the read cell; rd_data holds
//   mem_re/mem_we         RAM strobes (never both high); mem_rdata valid the
//   mem_addr/mem_wdata    cycle after mem_re
//   mem_rdata
//   stat_updates          (ARB_STATS_EN only) update writes since reset/clear
//   stat_saturations      (ARB_STATS_EN only) clamped updates since reset/clear
//   state_dbg             current FSM state encoding
//
// Build option: define ARB_STATS_EN to add the two statistics counters.
//
// Handshake: a request transfers on a rising edge where valid && ready.
// ready is only ever high in IDLE, only for the round-robin winner, only when
// no clear is pending or starting, and never depends on its own valid.
// -----------------------------------------------------------------------------
module occupancy_grid_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int CELL_WIDTH    = 8,
    parameter int LOG_ODDS_HIT  = 4,
    parameter int LOG_ODDS_MISS = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  busy,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic                  upd_hit,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data_valid,
    output logic [CELL_WIDTH-1:0] rd_data,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [CELL_WIDTH-1:0] mem_wdata,
    input  logic [CELL_WIDTH-1:0] mem_rdata,
`ifdef ARB_STATS_EN
    output logic [31:0]           stat_updates,
    output logic [15:0]           stat_saturations,
`endif
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        U_RD   = 3'd2,
        U_WAIT = 3'd3,
        U_WR   = 3'd4,
        R_RD   = 3'd5,
        R_WAIT = 3'd6
    } state_t;

    // rr_last encoding: which requester won the most recent grant.
    localparam logic RR_RD  = 1'b0;
    localparam logic RR_UPD = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CELL_WIDTH:0]   HIT_EXT  = (CELL_WIDTH+1)'(LOG_ODDS_HIT);
    localparam logic [CELL_WIDTH:0]   MISS_NEG = (CELL_WIDTH+1)'(-LOG_ODDS_MISS);
    localparam logic [CELL_WIDTH-1:0] CELL_MAX = {1'b0, {(CELL_WIDTH-1){1'b1}}};
    localparam logic [CELL_WIDTH-1:0] CELL_MIN = {1'b1, {(CELL_WIDTH-1){1'b0}}};

    state_t                  state, state_next;
    logic                    clear_pending, clear_pending_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_next;
    logic                    rr_last, rr_last_next;
    logic                    upd_hit_q, upd_hit_q_next;

    logic                    mem_re_next, mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_next;
    logic [CELL_WIDTH-1:0]   mem_wdata_next;
    logic                    rd_data_valid_next;
    logic [CELL_WIDTH-1:0]   rd_data_next;

`ifdef ARB_STATS_EN
    logic [31:0]             stat_updates_next;
    logic [15:0]             stat_saturations_next;
`endif

    logic                    clear_req;
    logic                    can_grant;
    logic                    upd_win, rd_win;
    logic                    upd_fire, rd_fire;

    logic [CELL_WIDTH:0]     cell_ext;
    logic [CELL_WIDTH:0]     delta_ext;
    logic [CELL_WIDTH:0]     sum_ext;
    logic                    upd_sat;
    logic [CELL_WIDTH-1:0]   upd_result;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    assign clear_req = clear_start | clear_pending;

    // Grants are withheld during reset so every output reads 0 while it is held.
    assign can_grant = (state == IDLE) && !clear_req && !reset;

    // With both requesters valid the one that did not win last time gets it;
    // with only one valid, that one wins. Each side looks only at the other's
    // valid so a ready never depends on its own valid.
    assign upd_win = !rd_valid  || (rr_last == RR_RD);
    assign rd_win  = !upd_valid || (rr_last == RR_UPD);

    assign upd_ready = can_grant && upd_win;
    assign rd_ready  = can_grant && rd_win;
    assign upd_fire  = upd_valid && upd_ready;
    assign rd_fire   = rd_valid && rd_ready;

    assign busy      = (state != IDLE) || clear_pending;
    assign state_dbg = state;

    // ------------------------------------------------------------------------
    // Saturating log-odds arithmetic
    // One extra bit of headroom makes the sum exact; overflow of the cell range
    // shows as disagreement between the top two bits of the wide sum.
    // ------------------------------------------------------------------------
    always_comb begin
        cell_ext   = {mem_rdata[CELL_WIDTH-1], mem_rdata};
        delta_ext  = upd_hit_q ? HIT_EXT : MISS_NEG;
        sum_ext    = cell_ext + delta_ext;
        upd_sat    = sum_ext[CELL_WIDTH] ^ sum_ext[CELL_WIDTH-1];
        upd_result = sum_ext[CELL_WIDTH-1:0];
        if (upd_sat) begin
            upd_result = sum_ext[CELL_WIDTH] ? CELL_MIN : CELL_MAX;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next         = state;
        clear_pending_next = clear_pending;
        clr_cnt_next       = clr_cnt;
        rr_last_next       = rr_last;
        upd_hit_q_next     = upd_hit_q;
        mem_re_next        = 1'b0;
        mem_we_next        = 1'b0;
        mem_addr_next      = mem_addr;
        mem_wdata_next     = mem_wdata;
        rd_data_valid_next = 1'b0;
        rd_data_next       = rd_data;
`ifdef ARB_STATS_EN
        stat_updates_next     = stat_updates;
        stat_saturations_next = stat_saturations;
`endif

        // A clear request that arrives mid-operation is remembered; one that
        // arrives during a sweep is redundant and dropped.
        if (clear_start && (state != IDLE) && (state != CLEAR)) begin
            clear_pending_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next         = CLEAR;
                    clear_pending_next = 1'b0;
                    mem_we_next        = 1'b1;
                    mem_addr_next      = clr_cnt;
                    mem_wdata_next     = '0;
`ifdef ARB_STATS_EN
                    stat_updates_next     = '0;
                    stat_saturations_next = '0;
`endif
                end else if (upd_fire) begin
                    state_next     = U_RD;
                    mem_re_next    = 1'b1;
                    mem_addr_next  = upd_addr;
                    upd_hit_q_next = upd_hit;
                    rr_last_next   = RR_UPD;
                end else if (rd_fire) begin
                    state_next    = R_RD;
                    mem_re_next   = 1'b1;
                    mem_addr_next = rd_addr;
                    rr_last_next  = RR_RD;
                end
            end

            CLEAR: begin
                // clr_cnt tracks the address on the port this cycle and wraps
                // back to 0 after the last cell.
                clr_cnt_next = clr_cnt + ADDR_ONE;
                if (clr_cnt == '1) begin
                    state_next = IDLE;
                end else begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = clr_cnt + ADDR_ONE;
                    mem_wdata_next = '0;
                end
            end

            U_RD: begin
                state_next = U_WAIT;
            end

            U_WAIT: begin
                // mem_rdata is valid now; the clamped result goes straight out
                // as the write data of the next cycle, same address.
                state_next     = U_WR;
                mem_we_next    = 1'b1;
                mem_wdata_next = upd_result;
`ifdef ARB_STATS_EN
                if (stat_updates != '1) begin
                    stat_updates_next = stat_updates + 32'd1;
                end
                if (upd_sat && (stat_saturations != '1)) begin
                    stat_saturations_next = stat_saturations + 16'd1;
                end
`endif
            end

            U_WR: begin
                state_next = IDLE;
            end

            R_RD: begin
                state_next = R_WAIT;
            end

            R_WAIT: begin
                state_next         = IDLE;
                rd_data_valid_next = 1'b1;
                rd_data_next       = mem_rdata;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            clr_cnt       <= '0;
            rr_last       <= RR_RD;
            upd_hit_q     <= 1'b0;
            mem_re        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
`ifdef ARB_STATS_EN
            stat_updates     <= '0;
            stat_saturations <= '0;
`endif
        end else begin
            state         <= state_next;
            clear_pending <= clear_pending_next;
            clr_cnt       <= clr_cnt_next;
            rr_last       <= rr_last_next;
            upd_hit_q     <= upd_hit_q_next;
            mem_re        <= mem_re_next;
            mem_we        <= mem_we_next;
            mem_addr      <= mem_addr_next;
            mem_wdata     <= mem_wdata_next;
            rd_data_valid <= rd_data_valid_next;
            rd_data       <= rd_data_next;
`ifdef ARB_STATS_EN
            stat_updates     <= stat_updates_next;
            stat_saturations <= stat_saturations_next;
`endif
        end
    end

endmodule

// File: tb/tb_occupancy_grid_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for occupancy_grid_arbiter with ADDR_WIDTH=4, CELL_WIDTH=8.
// A behavioural single-port RAM (one-cycle read latency) sits on the mem_*
// port. Every RAM write and every rd_data_valid pulse is popped from an
// expected queue tagged with the cycle it must appear in.
// -----------------------------------------------------------------------------
module tb_occupancy_grid_arbiter;

    localparam int AW = 4;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          clear_start;
    logic          busy;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_addr;
    logic          upd_hit;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    logic [CW-1:0] rd_data;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;
    logic [CW-1:0] mem_rdata;
    logic [2:0]    state_dbg;
`ifdef ARB_STATS_EN
    logic [31:0]   stat_updates;
    logic [15:0]   stat_saturations;
`endif

    occupancy_grid_arbiter #(
        .ADDR_WIDTH    (AW),
        .CELL_WIDTH    (CW),
        .LOG_ODDS_HIT  (4),
        .LOG_ODDS_MISS (1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .clear_start      (clear_start),
        .busy             (busy),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_addr         (upd_addr),
        .upd_hit          (upd_hit),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_addr          (rd_addr),
        .rd_data_valid    (rd_data_valid),
        .rd_data          (rd_data),
        .mem_re           (mem_re),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
`ifdef ARB_STATS_EN
        .stat_updates     (stat_updates),
        .stat_saturations (stat_saturations),
`endif
        .state_dbg        (state_dbg)
    );

    // ---------------- RAM model ----------------
    logic          preload_en = 1'b0;
    logic [AW-1:0] preload_addr = '0;
    logic [CW-1:0] preload_data = '0;
    logic [CW-1:0] ram [0:(1<<AW)-1];

    always @(posedge clock) begin
        if (preload_en) ram[preload_addr] <= preload_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Cycle index: after the posedge that starts cycle N, cyc == N.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int n_upd  = 0;
    int n_sat  = 0;
    logic [43:0] exp_wr_q[$];   // {cycle, addr, data}
    logic [39:0] exp_rd_q[$];   // {cycle, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        logic [43:0] we_e;
        logic [39:0] rd_e;
        if (mem_re) check("one_access_per_cycle", {63'd0, mem_we}, 64'd0);
        if (mem_we) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h at cycle %0d, expected no write",
                         mem_addr, mem_wdata, cyc);
            end else begin
                we_e = exp_wr_q.pop_front();
                check("ram_write{cycle,addr,data}", {20'd0, 32'(cyc), mem_addr, mem_wdata}, {20'd0, we_e});
            end
        end
        if (rd_data_valid) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_data_valid: got data=0x%0h at cycle %0d, expected none",
                         rd_data, cyc);
            end else begin
                rd_e = exp_rd_q.pop_front();
                check("rd_data{cycle,data}", {24'd0, 32'(cyc), rd_data}, {24'd0, rd_e});
            end
        end
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [8:0] sat_model(input logic [7:0] pre, input logic hit);
        int v;
        v = int'($signed(pre)) + (hit ? 4 : -1);
        if (v > 127)  return {1'b1, 8'h7F};
        if (v < -128) return {1'b1, 8'h80};
        return {1'b0, 8'(v)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [CW-1:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        tick();
        preload_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!busy && exp_wr_q.size() == 0 && exp_rd_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        tick();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: got busy=%0d pending=%0d, expected idle within 100 cycles",
                     name, busy, exp_wr_q.size() + exp_rd_q.size());
        end
    endtask

    task automatic do_update(input logic [AW-1:0] a, input logic h,
                             input logic [CW-1:0] exp_w, input bit sat);
        int acc = -1;
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_hit   = h;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (upd_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        tick();
        upd_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL upd_accept_timeout: got upd_ready=0, expected accept within 100 cycles");
        end else begin
            exp_wr_q.push_back({32'(acc + 3), a, exp_w});
            n_upd++;
            if (sat) n_sat++;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [CW-1:0] exp_d);
        int acc = -1;
        rd_valid = 1'b1;
        rd_addr  = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (rd_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        tick();
        rd_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL rd_accept_timeout: got rd_ready=0, expected accept within 100 cycles");
        end else begin
            exp_rd_q.push_back({32'(acc + 3), exp_d});
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          pre_en;
        logic [7:0]  pre;
        logic        hit;
        logic [7:0]  exp;
        bit          sat;
    } vec_t;
    vec_t vecs[10];

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got no finish, expected completion within 1 ms");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int g;
        bit ready_seen;
        logic [AW-1:0] ra;
        logic [7:0]    rp;
        logic          rh;
        logic [8:0]    rm;

        // pre, hit, written value, clamp engaged
        vecs[0] = '{1'b1, 8'd126, 1'b1, 8'd127, 1'b1};
        vecs[1] = '{1'b0, 8'd0,   1'b1, 8'd127, 1'b1};
        vecs[2] = '{1'b1, 8'h81,  1'b0, 8'h80,  1'b0};
        vecs[3] = '{1'b0, 8'd0,   1'b0, 8'h80,  1'b1};
        vecs[4] = '{1'b0, 8'd0,   1'b1, 8'h84,  1'b0};
        vecs[5] = '{1'b1, 8'd125, 1'b1, 8'd127, 1'b1};
        vecs[6] = '{1'b1, 8'd0,   1'b0, 8'hFF,  1'b0};
        vecs[7] = '{1'b1, 8'hFE,  1'b1, 8'd2,   1'b0};
        vecs[8] = '{1'b1, 8'd127, 1'b0, 8'd126, 1'b0};
        vecs[9] = '{1'b1, 8'd123, 1'b1, 8'd127, 1'b0};

        reset       = 1'b1;
        clear_start = 1'b0;
        upd_valid   = 1'b0;
        upd_addr    = '0;
        upd_hit     = 1'b0;
        rd_valid    = 1'b0;
        rd_addr     = '0;

        // ---- reset values ----
        repeat (3) tick();
        @(negedge clock);
        check("reset_outputs",
              {43'd0, busy, upd_ready, rd_ready, mem_re, mem_we, rd_data_valid, mem_addr, mem_wdata, rd_data},
              64'd0);
        check("reset_state", {61'd0, state_dbg}, 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("idle_both_ready", {62'd0, upd_ready, rd_ready}, 64'd3);
        tick();

        // ---- full clear sweep ----
        clear_start = 1'b1;
        t = cyc;
        for (int i = 0; i < 16; i++) exp_wr_q.push_back({32'(t + 1 + i), 4'(i), 8'd0});
        @(negedge clock);
        check("ready_during_clear_start", {62'd0, upd_ready, rd_ready}, 64'd0);
        tick();
        clear_start = 1'b0;
        @(negedge clock);
        check("clear_busy_start", {63'd0, busy}, 64'd1);
        tick();
        while (cyc < t + 16) tick();
        @(negedge clock);
        check("clear_busy_last_addr", {63'd0, busy}, 64'd1);
        tick();
        @(negedge clock);
        check("clear_done_busy", {63'd0, busy}, 64'd0);
        tick();

        // ---- round robin with both valids held, update first ----
        upd_valid = 1'b1;
        upd_addr  = 4'd9;
        upd_hit   = 1'b1;
        rd_valid  = 1'b1;
        rd_addr   = 4'd9;
        g = 0;
        for (int i = 0; i < 100 && g < 4; i++) begin
            @(negedge clock);
            if (upd_ready || rd_ready) begin
                check($sformatf("rr_grant%0d{upd,rd}", g), {62'd0, upd_ready, rd_ready},
                      (g % 2 == 0) ? 64'd2 : 64'd1);
                if (upd_ready) begin
                    exp_wr_q.push_back({32'(cyc + 3), 4'd9, 8'(4 * (g / 2 + 1))});
                    n_upd++;
                end else begin
                    exp_rd_q.push_back({32'(cyc + 3), 8'(4 * (g / 2 + 1))});
                end
                g++;
            end
            tick();
        end
        upd_valid = 1'b0;
        rd_valid  = 1'b0;
        if (g < 4) begin
            checks++;
            errors++;
            $display("FAIL rr_timeout: got %0d grants, expected 4", g);
        end
        wait_idle("rr");

        // ---- three hits then read back ----
        do_update(4'd5, 1'b1, 8'd4, 1'b0);
        do_update(4'd5, 1'b1, 8'd8, 1'b0);
        do_update(4'd5, 1'b1, 8'd12, 1'b0);
        do_read(4'd5, 8'd12);
        wait_idle("hits");
        repeat (3) tick();
        @(negedge clock);
        check("rd_data_held", {55'd0, rd_data_valid, rd_data}, {55'd0, 1'b0, 8'd12});
        tick();

        // ---- saturation table ----
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].pre_en) preload(4'd3, vecs[i].pre);
            do_update(4'd3, vecs[i].hit, vecs[i].exp, vecs[i].sat);
            wait_idle($sformatf("vec%0d", i));
        end

        // ---- random updates with read-back ----
        for (int i = 0; i < 8; i++) begin
            ra = 4'($urandom_range(0, 15));
            rp = 8'($urandom_range(0, 255));
            rh = 1'($urandom_range(0, 1));
            rm = sat_model(rp, rh);
            preload(ra, rp);
            do_update(ra, rh, rm[7:0], rm[8]);
            do_read(ra, rm[7:0]);
            wait_idle("random");
        end

`ifdef ARB_STATS_EN
        @(negedge clock);
        check("stat_updates", {32'd0, stat_updates}, 64'(n_upd));
        check("stat_saturations", {48'd0, stat_saturations}, 64'(n_sat));
        tick();
`endif

        // ---- clear_start during U_WAIT ----
        preload(4'd2, 8'd10);
        upd_valid = 1'b1;
        upd_addr  = 4'd2;
        upd_hit   = 1'b1;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (upd_ready) begin
                t = cyc;
                break;
            end
            tick();
        end
        tick();
        if (t < 0) begin
            upd_valid = 1'b0;
            checks++;
            errors++;
            $display("FAIL pend_accept_timeout: got upd_ready=0, expected accept within 100 cycles");
        end else begin
            exp_wr_q.push_back({32'(t + 3), 4'd2, 8'd14});
            for (int i = 0; i < 16; i++) exp_wr_q.push_back({32'(t + 5 + i), 4'(i), 8'd0});
            n_upd = 0;
            n_sat = 0;
            ready_seen = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                upd_valid   = 1'b0;
                rd_valid    = 1'b1;
                rd_addr     = 4'd0;
                clear_start = (k == 2);
                @(negedge clock);
                if (upd_ready || rd_ready) ready_seen = 1'b1;
                if (k == 4) check("pending_busy{busy,state}", {60'd0, busy, state_dbg}, {60'd0, 1'b1, 3'd0});
                tick();
            end
            rd_valid    = 1'b0;
            clear_start = 1'b0;
            @(negedge clock);
            check("pending_clear_done_busy", {63'd0, busy}, 64'd0);
            check("no_ready_while_pending", {63'd0, ready_seen}, 64'd0);
            tick();
        end
`ifdef ARB_STATS_EN
        @(negedge clock);
        check("stat_updates_zeroed", {32'd0, stat_updates}, 64'd0);
        check("stat_saturations_zeroed", {48'd0, stat_saturations}, 64'd0);
        tick();
`endif

        // ---- reset in the middle of a clear sweep ----
        for (int i = 8; i < 16; i++) preload(4'(i), 8'hA5);
        clear_start = 1'b1;
        t = cyc;
        for (int i = 0; i < 8; i++) exp_wr_q.push_back({32'(t + 1 + i), 4'(i), 8'd0});
        tick();
        clear_start = 1'b0;
        while (cyc < t + 8) tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        check("reset_abort_outputs",
              {43'd0, busy, upd_ready, rd_ready, mem_re, mem_we, rd_data_valid, mem_addr, mem_wdata, rd_data},
              64'd0);
        check("reset_abort_state", {61'd0, state_dbg}, 64'd0);
        repeat (5) tick();
        reset = 1'b0;
        repeat (20) tick();
        @(negedge clock);
        check("post_reset_idle", {63'd0, busy}, 64'd0);
        check("ram_addr8_untouched", {56'd0, ram[8]}, 64'hA5);
        check("ram_addr15_untouched", {56'd0, ram[15]}, 64'hA5);
        check("ram_addr7_cleared", {56'd0, ram[7]}, 64'd0);
        check("queues_drained", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
